// File: rtl/debug_overlay_pkg.sv
// Shared types and tables for the debug overlay: glyph type, character constants,
// ABI register names and the 5x7 font (ascii_tbl).
package debug_overlay_pkg;

    // Row 6 of the packed value is the top glyph row; bit 4 of a row is the leftmost pixel.
    typedef logic [6:0][4:0] glyph_t;

    localparam logic [7:0] CH_ZERO       = 8'h30;
    localparam logic [7:0] CH_NINE       = 8'h39;
    localparam logic [7:0] CH_UPPER_A    = 8'h41;
    localparam logic [7:0] CH_UPPER_F    = 8'h46;
    localparam logic [7:0] CH_COLON      = 8'h3A;
    localparam logic [7:0] CH_X          = 8'h78;
    localparam logic [7:0] CH_UNDERSCORE = 8'h5F;
    localparam logic [7:0] CH_SPACE      = 8'h20;

    localparam logic [39:0] ABI_NAME [32] = '{
        "zero:", "  ra:", "  sp:", "  gp:", "  tp:", "  t0:", "  t1:", "  t2:",
        "  s0:", "  s1:", "  a0:", "  a1:", "  a2:", "  a3:", "  a4:", "  a5:",
        "  a6:", "  a7:", "  s2:", "  s3:", "  s4:", "  s5:", "  s6:", "  s7:",
        "  s8:", "  s9:", " s10:", " s11:", "  t3:", "  t4:", "  t5:", "  t6:"
    };

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = CH_ZERO + {4'h0, nib};
        end else begin
            c = CH_UPPER_A + ({4'h0, nib} - 8'd10);
        end
        return c;
    endfunction

    function automatic glyph_t ascii_tbl(input logic [7:0] c);
        glyph_t g;
        case (c)
            "0": g = 35'b01110_10001_10011_10101_11001_10001_01110;
            "1": g = 35'b00100_01100_00100_00100_00100_00100_01110;
            "2": g = 35'b01110_10001_00001_00010_00100_01000_11111;
            "3": g = 35'b11111_00010_00100_00010_00001_10001_01110;
            "4": g = 35'b00010_00110_01010_10010_11111_00010_00010;
            "5": g = 35'b11111_10000_11110_00001_00001_10001_01110;
            "6": g = 35'b00110_01000_10000_11110_10001_10001_01110;
            "7": g = 35'b11111_00001_00010_00100_01000_01000_01000;
            "8": g = 35'b01110_10001_10001_01110_10001_10001_01110;
            "9": g = 35'b01110_10001_10001_01111_00001_00010_01100;
            "A": g = 35'b01110_10001_10001_11111_10001_10001_10001;
            "B": g = 35'b11110_10001_10001_11110_10001_10001_11110;
            "C": g = 35'b01110_10001_10000_10000_10000_10001_01110;
            "D": g = 35'b11100_10010_10001_10001_10001_10010_11100;
            "E": g = 35'b11111_10000_10000_11110_10000_10000_11111;
            "F": g = 35'b11111_10000_10000_11110_10000_10000_10000;
            ":": g = 35'b00000_01100_01100_00000_01100_01100_00000;
            "_": g = 35'b00000_00000_00000_00000_00000_00000_11111;
            "x": g = 35'b00000_00000_10001_01010_00100_01010_10001;
            "a": g = 35'b00000_00000_01110_00001_01111_10001_01111;
            "e": g = 35'b00000_00000_01110_10001_11111_10000_01110;
            "g": g = 35'b00000_01111_10001_10001_01111_00001_01110;
            "o": g = 35'b00000_00000_01110_10001_10001_10001_01110;
            "p": g = 35'b00000_00000_11110_10001_11110_10000_10000;
            "r": g = 35'b00000_00000_10110_11001_10000_10000_10000;
            "s": g = 35'b00000_00000_01110_10000_01110_00001_11110;
            "t": g = 35'b01000_01000_11100_01000_01000_01001_00110;
            "z": g = 35'b00000_00000_11111_00010_00100_01000_11111;
            default: g = 35'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/debug_overlay_renderer_if.sv
// Video pixel bus of the overlay stage: upstream counts/game pixel in, blended pixel out.
interface debug_overlay_renderer_if;
    logic [10:0] hcount_hdmi;
    logic [9:0]  vcount_hdmi;
    logic [7:0]  game_red;
    logic [7:0]  game_green;
    logic [7:0]  game_blue;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;

    modport master (
        output hcount_hdmi, vcount_hdmi, game_red, game_green, game_blue,
        input  red, green, blue, hcount_out, vcount_out
    );

    modport slave (
        input  hcount_hdmi, vcount_hdmi, game_red, game_green, game_blue,
        output red, green, blue, hcount_out, vcount_out
    );
endinterface

// File: rtl/debug_overlay_renderer_char_gen.sv
// overlay_char_gen: maps a panel cell (column, row, snapshot word) to its character code.
module overlay_char_gen
    import debug_overlay_pkg::*;
(
    input  logic [3:0]  cx,
    input  logic [4:0]  cy,
    input  logic [31:0] word,
    output logic [7:0]  char_code
);

    logic [39:0] name_s;
    logic [3:0]  nib_s;

    // Layout: 5-char name, "0x", upper half, '_', lower half.
    always_comb begin
        name_s = ABI_NAME[cy];
        case (cx)
            4'd7:    nib_s = word[31:28];
            4'd8:    nib_s = word[27:24];
            4'd9:    nib_s = word[23:20];
            4'd10:   nib_s = word[19:16];
            4'd12:   nib_s = word[15:12];
            4'd13:   nib_s = word[11:8];
            4'd14:   nib_s = word[7:4];
            4'd15:   nib_s = word[3:0];
            default: nib_s = 4'h0;
        endcase
        case (cx)
            4'd0:    char_code = name_s[39:32];
            4'd1:    char_code = name_s[31:24];
            4'd2:    char_code = name_s[23:16];
            4'd3:    char_code = name_s[15:8];
            4'd4:    char_code = name_s[7:0];
            4'd5:    char_code = CH_ZERO;
            4'd6:    char_code = CH_X;
            4'd11:   char_code = CH_UNDERSCORE;
            default: char_code = hex_ascii(nib_s);
        endcase
    end

endmodule

// File: rtl/debug_overlay_renderer.sv
// Register-file debug panel blended over the game pixel stream, fixed 2-cycle latency.
// Optional: define OVERLAY_BLEND_EN to show unlit panel pixels as the 50% dimmed game pixel.
module debug_overlay_renderer
    import debug_overlay_pkg::*;
#(
    parameter int          NUM_REGS     = 32,
    parameter int          SCALE_LOG2   = 4,
    parameter int          ORIGIN_X     = 0,
    parameter int          ORIGIN_Y     = 0,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] HILITE_COLOR = 24'hFFFF00,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [31:0]               reg_file [32],
    input  logic                      debug_mode,
    input  logic                      freeze_in,
    debug_overlay_renderer_if.slave   vid
);

    localparam logic [11:0] ORG_X = 12'(ORIGIN_X);
    localparam logic [11:0] ORG_Y = 12'(ORIGIN_Y);
    localparam logic [11:0] ROWS  = 12'(NUM_REGS);

    logic [31:0] shadow_r [32];
    logic [31:0] prev_r   [32];
    logic        chg_en_r;
    logic        overlay_on_r;

    logic        fs_s;
    logic        in_panel_s;
    logic        chg_row_s;
    logic [11:0] dx_s, dy_s, cx_full_s, cy_full_s;
    logic [3:0]  cx_s;
    logic [4:0]  cy_s;
    logic [7:0]  char_s;

    logic [SCALE_LOG2-1:0] ox_r, oy_r;
    logic [7:0]  char_r;
    logic        in_panel_r;
    logic        chg_r;
    logic [23:0] game_r;
    logic [10:0] hcount_r;
    logic [9:0]  vcount_r;

    logic [2:0]  row_s, col_s;
    logic        lit_s;
    glyph_t      glyph_s;
    logic [23:0] bg_s, pix_s;

    logic [23:0] pix_r;
    logic [10:0] hcount_out_r;
    logic [9:0]  vcount_out_r;

    // Stage 0: frame-start detect and panel geometry from the incoming counts.
    always_comb begin
        fs_s       = (vid.hcount_hdmi == 11'd0) && (vid.vcount_hdmi == 10'd0);
        dx_s       = {1'b0, vid.hcount_hdmi} - ORG_X;
        dy_s       = {2'b00, vid.vcount_hdmi} - ORG_Y;
        cx_full_s  = dx_s >> SCALE_LOG2;
        cy_full_s  = dy_s >> SCALE_LOG2;
        cx_s       = cx_full_s[3:0];
        cy_s       = cy_full_s[4:0];
        in_panel_s = overlay_on_r
                  && ({1'b0, vid.hcount_hdmi} >= ORG_X)
                  && ({2'b00, vid.vcount_hdmi} >= ORG_Y)
                  && (cx_full_s < 12'd16)
                  && (cy_full_s < ROWS);
        // A row is "changed" when the last unfrozen snapshot moved it; freezing disables this.
        chg_row_s  = chg_en_r && (shadow_r[cy_s] != prev_r[cy_s]);
    end

    overlay_char_gen u_char_gen (
        .cx        (cx_s),
        .cy        (cy_s),
        .word      (shadow_r[cy_s]),
        .char_code (char_s)
    );

    // Frame-start snapshot of the register file and panel enable.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overlay_on_r <= 1'b0;
            chg_en_r     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                shadow_r[i] <= 32'd0;
                prev_r[i]   <= 32'd0;
            end
        end else if (fs_s) begin
            overlay_on_r <= debug_mode;
            if (freeze_in) begin
                chg_en_r <= 1'b0;
            end else begin
                chg_en_r <= 1'b1;
                for (int i = 0; i < 32; i++) begin
                    shadow_r[i] <= reg_file[i];
                    prev_r[i]   <= shadow_r[i];
                end
            end
        end
    end

    // Stage 1: cell offset, character, panel flag, highlight bit, game pixel and counts.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ox_r       <= '0;
            oy_r       <= '0;
            char_r     <= 8'd0;
            in_panel_r <= 1'b0;
            chg_r      <= 1'b0;
            game_r     <= 24'd0;
            hcount_r   <= 11'd0;
            vcount_r   <= 10'd0;
        end else begin
            ox_r       <= dx_s[SCALE_LOG2-1:0];
            oy_r       <= dy_s[SCALE_LOG2-1:0];
            char_r     <= char_s;
            in_panel_r <= in_panel_s;
            chg_r      <= chg_row_s;
            game_r     <= {vid.game_red, vid.game_green, vid.game_blue};
            hcount_r   <= vid.hcount_hdmi;
            vcount_r   <= vid.vcount_hdmi;
        end
    end

    // Stage 2: glyph lookup and colour select.
    always_comb begin
        glyph_s = ascii_tbl(char_r);
        row_s   = 3'(oy_r >> (SCALE_LOG2 - 3));
        col_s   = 3'(ox_r >> (SCALE_LOG2 - 3));
        if ((row_s < 3'd7) && (col_s < 3'd5)) begin
            lit_s = glyph_s[3'd6 - row_s][3'd4 - col_s];
        end else begin
            lit_s = 1'b0;
        end
`ifdef OVERLAY_BLEND_EN
        bg_s = {game_r[23:16] >> 3'd1, game_r[15:8] >> 3'd1, game_r[7:0] >> 3'd1};
`else
        bg_s = BG_COLOR;
`endif
        if (!in_panel_r) begin
            pix_s = game_r;
        end else if (lit_s) begin
            if (chg_r) begin
                pix_s = HILITE_COLOR;
            end else begin
                pix_s = FG_COLOR;
            end
        end else begin
            pix_s = bg_s;
        end
    end

    // Output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pix_r        <= 24'd0;
            hcount_out_r <= 11'd0;
            vcount_out_r <= 10'd0;
        end else begin
            pix_r        <= pix_s;
            hcount_out_r <= hcount_r;
            vcount_out_r <= vcount_r;
        end
    end

    assign vid.red        = pix_r[23:16];
    assign vid.green      = pix_r[15:8];
    assign vid.blue       = pix_r[7:0];
    assign vid.hcount_out = hcount_out_r;
    assign vid.vcount_out = vcount_out_r;

endmodule
